// File: rtl/alu_op_sequencer.sv
// Sequences one command at a time through an external combinational 4-bit ALU:
// accept, drive the ALU for one cycle, then hold the captured result for the consumer.
module alu_op_sequencer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_chain,
  output logic             alu_en,
  output logic [2:0]       alu_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_result,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_result,
  output logic [2:0]       out_flags,
  output logic [CNT_W-1:0] op_count,
  output logic             ovf_sticky,
  input  logic             clr_stats
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [3:0]       a_q;
  logic [3:0]       b_q;
  logic [3:0]       last_result_q;
  logic [3:0]       out_result_q;
  logic [2:0]       out_flags_q;
  logic [CNT_W-1:0] op_count_q;
  logic             ovf_sticky_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      last_result_q <= '0;
      out_result_q  <= '0;
      out_flags_q   <= '0;
      op_count_q    <= '0;
      ovf_sticky_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q    <= in_op;
            a_q     <= in_chain ? last_result_q : in_a;
            b_q     <= in_b;
            state_q <= StExec;
          end
        end
        StExec: begin
          out_result_q  <= alu_result;
          out_flags_q   <= {alu_overflow, alu_carry, alu_zero};
          last_result_q <= alu_result;
          state_q       <= StHold;
        end
        StHold: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // A clear request beats a simultaneous handshake.
      if (clr_stats) begin
        op_count_q   <= '0;
        ovf_sticky_q <= 1'b0;
      end else if (state_q == StHold && out_ready) begin
        op_count_q <= op_count_q + 1'b1;
        if (out_flags_q[2]) ovf_sticky_q <= 1'b1;
      end
    end
  end

  always_comb begin
    in_ready   = (state_q == StIdle);
    alu_en     = (state_q == StExec);
    out_valid  = (state_q == StHold);
    alu_op     = op_q;
    alu_a      = a_q;
    alu_b      = b_q;
    out_result = out_result_q;
    out_flags  = out_flags_q;
    op_count   = op_count_q;
    ovf_sticky = ovf_sticky_q;
  end

endmodule
